multi_digit_segment_driver: RTL and testbench

//   Parametrised N-digit multiplexed 7-segment driver for the calculator display path.

---
 rtl/multi_digit_segment_driver.sv | 246 ++++++++++++++++++++++++
 tb/tb_multi_digit_segment_driver.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_segment_driver.sv
// rtl/multi_digit_segment_driver.sv - N-digit multiplexed 7-segment driver with sequential BCD conversion
// Ports:
//   clock_100Mhz    system clock
//   reset           synchronous active-low reset
//   load            one-cycle capture request for value/negative/mode/dot_mask
//   value           unsigned magnitude to display
//   negative        show a minus sign (mode 0 only)
//   mode            0 number, 1 "Err", 2/3 blank
//   dot_mask        per-digit dot enable, MSB = leftmost digit
//   busy            conversion in progress, load ignored while high
//   overflow        last committed number did not fit the display
//   Anode_Activate  active-low one-hot digit enable, MSB = leftmost digit
//   LED_out         active-low segments, bit6=a .. bit0=g
//   Dot_Enable      active-low decimal point
module multi_digit_segment_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int VALUE_WIDTH = 14,
   parameter int SCAN_DIV    = 2048,
   parameter int BLANK_LEAD  = 1
) (
   input  logic                   clock_100Mhz,
   input  logic                   reset,
   input  logic                   load,
   input  logic [VALUE_WIDTH-1:0] value,
   input  logic                   negative,
   input  logic [1:0]             mode,
   input  logic [NUM_DIGITS-1:0]  dot_mask,
   output logic                   busy,
   output logic                   overflow,
   output logic [NUM_DIGITS-1:0]  Anode_Activate,
   output logic [6:0]             LED_out,
   output logic                   Dot_Enable
);

   // ceil(VALUE_WIDTH * log10(2)) decimal digits, log10(2) ~= 0.30103
   localparam int BCD_NIB = (VALUE_WIDTH * 30103 + 99999) / 100000;
   localparam int BCD_W   = 4 * BCD_NIB;
   // BCD view padded so every display digit has a nibble even when BCD_NIB < NUM_DIGITS
   localparam int EXT_NIB = (BCD_NIB > NUM_DIGITS) ? BCD_NIB : NUM_DIGITS;
   localparam int EXT_W   = 4 * EXT_NIB;
   localparam int CNT_W   = $clog2(VALUE_WIDTH + 1);
   localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b1111110;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_R     = 7'b1111010;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

   state_t                 state;
   logic [CNT_W-1:0]       iter;
   logic [VALUE_WIDTH-1:0] sh;
   logic [BCD_W-1:0]       bcd;
   logic [BCD_W-1:0]       bcd_adj;
   logic [EXT_W-1:0]       bcd_ext;
   logic                   sh_neg;
   logic [1:0]             sh_mode;
   logic [NUM_DIGITS-1:0]  sh_dots;
   logic                   hi_any;
   logic                   neg_hi;
   logic                   commit_ovf;
   logic                   unused_top;

   logic [3:0]             disp_dig [NUM_DIGITS];
   logic [1:0]             disp_mode;
   logic                   disp_sign;
   logic [NUM_DIGITS-1:0]  disp_dots;

   logic [PRE_W-1:0]       pre;
   logic [IDX_W-1:0]       idx;

   logic [NUM_DIGITS-1:0]  lead_blank;
   logic                   zero_run;
   logic [3:0]             cur_dig;
   logic                   cur_dot;
   logic                   cur_lead;
   logic [NUM_DIGITS-1:0]  anode_next;
   logic [6:0]             seg_next;
   logic                   dot_next;

   function automatic logic [6:0] digit_seg(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return SEG_BLANK;
      endcase
   endfunction

   // add-3 correction applied before each shift
   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < BCD_NIB; k++) begin
         if (bcd[4*k +: 4] >= 4'd5)
            bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
   end

   // top bit of the adjusted value is always zero given the BCD sizing
   assign unused_top = bcd_adj[BCD_W-1];

   // overflow judged from the finished BCD: any nonzero nibble beyond the display width
   always_comb begin
      bcd_ext = '0;
      bcd_ext[BCD_W-1:0] = bcd;
      hi_any = 1'b0;
      neg_hi = 1'b0;
      for (int k = 0; k < EXT_NIB; k++) begin
         if (bcd_ext[4*k +: 4] != 4'd0) begin
            if (k >= NUM_DIGITS)     hi_any = 1'b1;
            if (k >= NUM_DIGITS - 1) neg_hi = 1'b1;
         end
      end
      commit_ovf = (sh_mode == 2'd0) && (hi_any || (sh_neg && neg_hi));
   end

   always_ff @(posedge clock_100Mhz) begin
      if (!reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         overflow  <= 1'b0;
         iter      <= '0;
         sh        <= '0;
         bcd       <= '0;
         sh_neg    <= 1'b0;
         sh_mode   <= 2'd2;
         sh_dots   <= '0;
         disp_mode <= 2'd2;
         disp_sign <= 1'b0;
         disp_dots <= '0;
         for (int d = 0; d < NUM_DIGITS; d++) disp_dig[d] <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (load) begin
                  sh      <= value;
                  bcd     <= '0;
                  iter    <= '0;
                  sh_neg  <= negative;
                  sh_mode <= mode;
                  sh_dots <= dot_mask;
                  busy    <= 1'b1;
                  state   <= S_CONV;
               end
            end
            S_CONV: begin
               bcd  <= {bcd_adj[BCD_W-2:0], sh[VALUE_WIDTH-1]};
               sh   <= sh << 1;
               iter <= iter + 1'b1;
               if (iter == CNT_W'(VALUE_WIDTH - 1))
                  state <= S_COMMIT;
            end
            S_COMMIT: begin
               for (int d = 0; d < NUM_DIGITS; d++)
                  disp_dig[d] <= bcd_ext[4*(NUM_DIGITS-1-d) +: 4];
               disp_mode <= commit_ovf ? 2'd1 : sh_mode;
               // a negative zero shows as plain 0
               disp_sign <= sh_neg && (|bcd) && (sh_mode == 2'd0);
               disp_dots <= sh_dots;
               overflow  <= commit_ovf;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_100Mhz) begin
      if (!reset) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
         pre <= '0;
         idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   // zeros left of the first nonzero digit; the rightmost digit is never blanked
   always_comb begin
      zero_run = 1'b1;
      lead_blank = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         zero_run = zero_run & (disp_dig[d] == 4'd0);
         lead_blank[d] = zero_run & (BLANK_LEAD != 0) & (d != NUM_DIGITS - 1);
      end
   end

   always_comb begin
      cur_dig    = 4'd0;
      cur_dot    = 1'b0;
      cur_lead   = 1'b0;
      anode_next = '1;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (idx == IDX_W'(d)) begin
            cur_dig  = disp_dig[d];
            cur_dot  = disp_dots[NUM_DIGITS-1-d];
            cur_lead = lead_blank[d];
            anode_next[NUM_DIGITS-1-d] = 1'b0;
         end
      end
      seg_next = SEG_BLANK;
      dot_next = 1'b1;
      case (disp_mode)
         2'd0: begin
            dot_next = ~cur_dot;
            if (disp_sign && idx == '0)
               seg_next = SEG_MINUS;
            else if (!cur_lead)
               seg_next = digit_seg(cur_dig);
         end
         2'd1: begin
            dot_next = ~cur_dot;
            if (idx == '0)
               seg_next = SEG_E;
            else if (idx != IDX_W'(NUM_DIGITS - 1))
               seg_next = SEG_R;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_100Mhz) begin
      if (!reset) begin
         Anode_Activate <= '1;
         LED_out        <= SEG_BLANK;
         Dot_Enable     <= 1'b1;
      end else begin
         Anode_Activate <= anode_next;
         LED_out        <= seg_next;
         Dot_Enable     <= dot_next;
      end
   end

endmodule

// File: tb/tb_multi_digit_segment_driver.sv
// tb/tb_multi_digit_segment_driver.sv - randomized self-checking bench for multi_digit_segment_driver
module tb_multi_digit_segment_driver;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic [19:0] value = '0;
   logic        negative = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [5:0]  dot = '0;

   logic       busy_a, ovf_a, dp_a, busy_b, ovf_b, dp_b, busy_c, ovf_c, dp_c, busy_d, ovf_d, dp_d;
   logic [3:0] an_a, an_b, an_c;
   logic [5:0] an_d;
   logic [6:0] led_a, led_b, led_c, led_d;

   int n_checks = 0;
   int n_fail = 0;

   int c4_v, c4_md, c4_mask, c6_v, c6_md, c6_mask;
   bit c4_neg, c6_neg;

   logic [7:0] cap_a [4];
   logic [7:0] cap_b [4];
   logic [7:0] cap_c [4];
   logic [7:0] cap_d [6];
   bit   [3:0] seen_a, seen_b, seen_c;
   bit   [5:0] seen_d;

   logic [6:0] seg_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

   always #5 clk = ~clk;

   multi_digit_segment_driver #(.NUM_DIGITS(4), .VALUE_WIDTH(14), .SCAN_DIV(2048), .BLANK_LEAD(1)) dut_a (
      .clock_100Mhz(clk), .reset(reset), .load(load), .value(value[13:0]), .negative(negative),
      .mode(mode), .dot_mask(dot[3:0]), .busy(busy_a), .overflow(ovf_a),
      .Anode_Activate(an_a), .LED_out(led_a), .Dot_Enable(dp_a));

   multi_digit_segment_driver #(.NUM_DIGITS(4), .VALUE_WIDTH(14), .SCAN_DIV(4), .BLANK_LEAD(1)) dut_b (
      .clock_100Mhz(clk), .reset(reset), .load(load), .value(value[13:0]), .negative(negative),
      .mode(mode), .dot_mask(dot[3:0]), .busy(busy_b), .overflow(ovf_b),
      .Anode_Activate(an_b), .LED_out(led_b), .Dot_Enable(dp_b));

   multi_digit_segment_driver #(.NUM_DIGITS(4), .VALUE_WIDTH(14), .SCAN_DIV(4), .BLANK_LEAD(0)) dut_c (
      .clock_100Mhz(clk), .reset(reset), .load(load), .value(value[13:0]), .negative(negative),
      .mode(mode), .dot_mask(dot[3:0]), .busy(busy_c), .overflow(ovf_c),
      .Anode_Activate(an_c), .LED_out(led_c), .Dot_Enable(dp_c));

   multi_digit_segment_driver #(.NUM_DIGITS(6), .VALUE_WIDTH(20), .SCAN_DIV(4), .BLANK_LEAD(1)) dut_d (
      .clock_100Mhz(clk), .reset(reset), .load(load), .value(value), .negative(negative),
      .mode(mode), .dot_mask(dot), .busy(busy_d), .overflow(ovf_d),
      .Anode_Activate(an_d), .LED_out(led_d), .Dot_Enable(dp_d));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pow10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic bit model_ovf(input int n, input int v, input bit neg, input int md);
      return (md == 0) && ((v >= pow10(n)) || (neg && v >= pow10(n - 1)));
   endfunction

   // expected {Dot_Enable, LED_out} for display position d (0 = leftmost)
   function automatic logic [7:0] model_digit(input int n, input bit bl, input int v, input bit neg,
                                              input int md, input int mask, input int d);
      int em;
      int k;
      logic [6:0] s;
      bit dp;
      em = model_ovf(n, v, neg, md) ? 1 : md;
      if (em >= 2) return {1'b1, 7'h7F};
      dp = ((mask >> (n - 1 - d)) & 1) != 0;
      if (em == 1) begin
         if (d == 0) s = 7'b0110000;
         else if (d == n - 1) s = 7'h7F;
         else s = 7'b1111010;
      end else begin
         k = n - 1 - d;
         if (neg && v != 0 && d == 0) s = 7'b1111110;
         else if (bl && k > 0 && v < pow10(k)) s = 7'h7F;
         else s = seg_tab[(v / pow10(k)) % 10];
      end
      return {~dp, s};
   endfunction

   task automatic do_load(input int v, input bit ng, input int md, input int mk, input bit upd4, input bit upd6);
      value = 20'(v);
      negative = ng;
      mode = 2'(md);
      dot = 6'(mk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      if (upd4) begin
         c4_v = v % 16384; c4_neg = ng; c4_md = md; c4_mask = mk & 15;
      end
      if (upd6) begin
         c6_v = v % (1 << 20); c6_neg = ng; c6_md = md; c6_mask = mk & 63;
      end
   endtask

   task automatic scan(input int cycles);
      bit oh_bad;
      bit order_bad;
      int pd;
      seen_b = '0; seen_c = '0; seen_d = '0;
      oh_bad = 0; order_bad = 0; pd = -1;
      repeat (cycles) begin
         @(negedge clk);
         if ($countones(~an_b) != 1 || $countones(~an_c) != 1 || $countones(~an_d) != 1) oh_bad = 1;
         for (int d = 0; d < 4; d++) begin
            if (!an_b[3-d]) begin cap_b[d] = {dp_b, led_b}; seen_b[d] = 1'b1; end
            if (!an_c[3-d]) begin cap_c[d] = {dp_c, led_c}; seen_c[d] = 1'b1; end
         end
         for (int d = 0; d < 6; d++) begin
            if (!an_d[5-d]) begin
               cap_d[d] = {dp_d, led_d};
               seen_d[d] = 1'b1;
               if (pd >= 0 && pd != d && d != (pd + 1) % 6) order_bad = 1;
               pd = d;
            end
         end
      end
      check("scan_onehot", 32'(oh_bad), 0);
      check("scan_order6", 32'(order_bad), 0);
   endtask

   task automatic verify(input string tag);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("%s b%0d", tag, d), seen_b[d] ? 32'(cap_b[d]) : 32'hDEAD,
               32'(model_digit(4, 1, c4_v, c4_neg, c4_md, c4_mask, d)));
         check($sformatf("%s c%0d", tag, d), seen_c[d] ? 32'(cap_c[d]) : 32'hDEAD,
               32'(model_digit(4, 0, c4_v, c4_neg, c4_md, c4_mask, d)));
      end
      for (int d = 0; d < 6; d++)
         check($sformatf("%s d%0d", tag, d), seen_d[d] ? 32'(cap_d[d]) : 32'hDEAD,
               32'(model_digit(6, 1, c6_v, c6_neg, c6_md, c6_mask, d)));
      check($sformatf("%s ovf_b", tag), 32'(ovf_b), 32'(model_ovf(4, c4_v, c4_neg, c4_md)));
      check($sformatf("%s ovf_c", tag), 32'(ovf_c), 32'(model_ovf(4, c4_v, c4_neg, c4_md)));
      check($sformatf("%s ovf_d", tag), 32'(ovf_d), 32'(model_ovf(6, c6_v, c6_neg, c6_md)));
   endtask

   task automatic settle_verify(input string tag);
      repeat (30) @(negedge clk);
      scan(30);
      verify(tag);
   endtask

   initial begin
      int cnt_a, cnt_d, run, trans;
      logic [3:0] prev;
      bit fell;

      c4_v = 0; c4_neg = 0; c4_md = 2; c4_mask = 0;
      c6_v = 0; c6_neg = 0; c6_md = 2; c6_mask = 0;

      // reset
      repeat (3) @(negedge clk);
      check("rst an_a", 32'(an_a), 32'hF);
      check("rst led_a", 32'(led_a), 32'h7F);
      check("rst dp_a", 32'(dp_a), 1);
      check("rst busy_a", 32'(busy_a), 0);
      check("rst ovf_a", 32'(ovf_a), 0);
      check("rst an_d", 32'(an_d), 32'h3F);
      reset = 1'b1;
      @(negedge clk);
      check("first an_a", 32'(an_a), 32'b0111);
      check("first an_d", 32'(an_d), 32'b011111);
      check("first led_a", 32'(led_a), 32'h7F);

      // 1234: busy length, scan order and dwell on the slow-scan instance
      do_load(1234, 0, 0, 0, 1, 1);
      check("busy_next", 32'(busy_a), 1);
      cnt_a = 0; cnt_d = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy_a) cnt_a++;
         if (busy_d) cnt_d++;
         @(negedge clk);
      end
      check("busy_len14", 32'(cnt_a), 15);
      check("busy_len20", 32'(cnt_d), 21);
      seen_a = '0; prev = an_a; run = 1; trans = 0;
      for (int i = 0; i < 5 * 2048 + 16; i++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++)
            if (!an_a[3-d]) begin cap_a[d] = {dp_a, led_a}; seen_a[d] = 1'b1; end
         if (an_a == prev) run++;
         else begin
            if (trans > 0) check("a_dwell", 32'(run), 2048);
            check("a_order", 32'(an_a), 32'({prev[0], prev[3:1]}));
            trans++;
            prev = an_a;
            run = 1;
         end
      end
      check("a_trans", 32'(trans >= 4), 1);
      for (int d = 0; d < 4; d++)
         check($sformatf("n1234 a%0d", d), seen_a[d] ? 32'(cap_a[d]) : 32'hDEAD,
               32'(model_digit(4, 1, 1234, 0, 0, 0, d)));
      scan(30);
      verify("n1234");

      do_load(7, 1, 0, 0, 1, 1);
      settle_verify("neg7");

      do_load(10000, 0, 0, 0, 1, 1);
      settle_verify("ovf10000");
      do_load(999, 1, 0, 0, 1, 1);
      settle_verify("neg999");
      do_load(1000, 1, 0, 4'b1010, 1, 1);
      settle_verify("negovf1000");

      // second load while busy is dropped
      do_load(42, 0, 0, 0, 1, 1);
      do_load(55, 0, 0, 0, 0, 0);
      settle_verify("busy_ignore");

      // load in the cycle busy falls is accepted (6-digit instance still busy)
      do_load(321, 0, 0, 0, 1, 1);
      fell = 0;
      for (int i = 0; i < 40 && !fell; i++) begin
         if (!busy_b) fell = 1;
         else @(negedge clk);
      end
      check("busy_fall_seen", 32'(fell), 1);
      do_load(654, 0, 0, 0, 1, 0);
      check("busy_reaccept", 32'(busy_b), 1);
      settle_verify("fall_accept");

      // reset mid-conversion
      do_load(1234, 0, 0, 0, 1, 1);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst busy_b", 32'(busy_b), 0);
      check("midrst busy_d", 32'(busy_d), 0);
      c4_md = 2; c4_neg = 0; c6_md = 2; c6_neg = 0;
      settle_verify("midrst");

      do_load(123456, 0, 0, 6'b000100, 1, 1);
      settle_verify("six123456");

      for (int it = 0; it < 40; it++) begin
         int v;
         int md;
         case ($urandom_range(0, 5))
            0: v = $urandom_range(0, 16383);
            1: v = $urandom_range(0, 99);
            2: v = 9999 + $urandom_range(0, 1);
            3: v = 999 + $urandom_range(0, 1);
            4: v = 0;
            default: v = $urandom_range(0, 9999);
         endcase
         md = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
         do_load(v, 1'($urandom_range(0, 1)), md, $urandom_range(0, 63), 1, 1);
         settle_verify("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
